csel_adder_pipe: RTL and testbench
==================================

Name: csel_adder_pipe

Overview:
- Parametrised, pipelined successor to the 16-bit carry-select adder.
- Computes A+B+cin or A−B, one carry-select block per pipeline stage, with valid/ready flow control on both sides.
- Sits between operand-producing logic and the ALU writeback path.
- Sustains one result per clock when the output is not stalled.

Parameters:
- WIDTH, 16: operand and sum width in bits.
- BLOCK, 4: carry-select block width. WIDTH must be an integer multiple of BLOCK; any other value is an elaboration error.
- NBLK, WIDTH/BLOCK (derived, localparam): number of blocks, which equals the number of pipeline stages.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  WIDTH  operand A (unsigned / two's complement)
- b  in  WIDTH  operand B
- cin  in  1  carry-in; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A−B, implemented as A+~B+1
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB; for sub=1, 1 means no borrow (A≥B unsigned)
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset, asserted asynchronously while rst_n=0: every valid bit, sum, cout, ovf and every pipeline register is cleared to 0. Release is synchronous to clk.
- Pipeline advance enable: adv = out_ready | ~out_valid.
  - in_ready = adv, combinational.
  - All stages shift together only when adv=1.
  - When adv=0, every register holds.
- Stage 0 captures the beat on an edge where in_valid & in_ready:
  - a.
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - The valid bit.
- If in_valid=0 on an edge where adv=1, a bubble (valid=0) enters the pipe. Bubbles are not collapsed.
- Stage k, for k = 0..NBLK−1:
  - Computes block k bits [k*BLOCK +: BLOCK] twice: once with carry-in 0 and once with carry-in 1.
  - Selects one result with the carry registered from stage k−1 (c0 for k=0).
  - Registers the selected BLOCK-bit slice and the block carry-out.
- Operand slices for blocks not yet computed travel alongside in skew registers. Sum slices already computed are also carried forward. Both are cleared on reset.
- Final stage:
  - cout is the carry out of block NBLK−1.
  - ovf = carry into bit WIDTH−1 XOR cout. The carry into the MSB is captured in the last stage.
- Latency:
  - A beat accepted at edge t appears with out_valid=1 after edge t+NBLK−1, i.e. NBLK register stages. This is 4 cycles for WIDTH=16, BLOCK=4.
  - Throughput is 1 beat/cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, sum, cout and ovf hold stable. Holding outputs also backpressures in_ready to 0 in the same cycle.
- Simultaneous events: with out_valid=1, out_ready=1 and in_valid=1 on the same edge, the pipe shifts, the output beat retires and a new beat enters. No beat is lost or duplicated.
- Degenerate case BLOCK=WIDTH: single stage, latency 1.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops to 0 immediately (asynchronous). No partial result is ever presented.
- Output values while out_valid=0 are don't-care for checking. The RTL does not force them.

Test Plan:
- Reset/basic, WIDTH=16, BLOCK=4: a=2, b=2, cin=1, sub=0 → sum=5, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- Full carry ripple: a=16'hFFFF, b=0, cin=1 → sum=0, cout=1, ovf=0. Then a=16'h7FFF, b=1, cin=0 → sum=16'h8000, cout=0, ovf=1.
- Subtract:
  - a=100, b=3, sub=1, cin=1 (ignored) → sum=97, cout=1, ovf=0.
  - a=3, b=12, sub=1 → sum=16'hFFF7, cout=0.
  - a=16'h8000, b=1, sub=1 → sum=16'h7FFF, ovf=1.
- Backpressure:
  - Stream 6 beats back-to-back; hold out_ready=0 for 3 cycles once out_valid rises.
  - in_ready must be 0 during the stall and outputs must stay stable.
  - All 6 results must emerge in order with no drop or duplicate.
  - Include interleaved in_valid=0 bubbles.
- Reset mid-stream: assert rst_n=0 asynchronously while 3 beats are in flight → out_valid=0 immediately. After release, no stale beat appears. A new beat a=12, b=3, cin=1 yields sum=16 after 4 cycles.
- Parameter sweep (WIDTH,BLOCK) = (8,8), (32,4), (32,8): random streams compared against a reference model of a+b+cin and a−b, including cout/ovf; latency must equal NBLK in every case.

Source files
------------

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select add/sub, one BLOCK-bit slice per stage; latency NBLK cycles.
// Whole pipe advances only when the output beat is taken or empty; in_ready mirrors that.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NBLK = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_param
    $error("csel_adder_pipe: WIDTH must be an integer multiple of BLOCK");
  end

  logic adv;
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 0; k < NBLK; k++) begin : stg
    localparam int LO = k * BLOCK;
    // y holds b_eff for this block and all later ones, right-aligned
    localparam int YW = WIDTH - LO;

    logic [WIDTH-1:0] x_src, x_nxt, x_q;
    logic [YW-1:0]    y_src;
    logic             c_src, v_src, c_q, v_q;
    logic [BLOCK:0]   r0, r1, sel;

    if (k == 0) begin : g_src
      assign x_src = a;
      assign y_src = sub ? ~b : b;
      assign c_src = sub | cin;
      assign v_src = in_valid;
    end else begin : g_src
      assign x_src = stg[k-1].x_q;
      assign y_src = stg[k-1].g_y.y_q;
      assign c_src = stg[k-1].c_q;
      assign v_src = stg[k-1].v_q;
    end

    assign r0  = {1'b0, x_src[LO +: BLOCK]} + {1'b0, y_src[BLOCK-1:0]};
    assign r1  = {1'b0, x_src[LO +: BLOCK]} + {1'b0, y_src[BLOCK-1:0]} + {{BLOCK{1'b0}}, 1'b1};
    assign sel = c_src ? r1 : r0;

    // x carries finished sum slices below LO and untouched A slices above
    always_comb begin
      x_nxt = x_src;
      x_nxt[LO +: BLOCK] = sel[BLOCK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        x_q <= x_nxt;
        c_q <= sel[BLOCK];
        v_q <= v_src;
      end
    end

    if (k < NBLK - 1) begin : g_y
      logic [YW-BLOCK-1:0] y_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   y_q <= '0;
        else if (adv) y_q <= y_src[YW-1:BLOCK];
      end
    end else begin : g_last
      logic ovf_q;
      // carry into the MSB recovered as a ^ b_eff ^ sum at that bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= x_src[WIDTH-1] ^ y_src[BLOCK-1] ^ sel[BLOCK-1] ^ sel[BLOCK];
      end
    end
  end

  assign out_valid = stg[NBLK-1].v_q;
  assign sum       = stg[NBLK-1].x_q;
  assign cout      = stg[NBLK-1].c_q;
  assign ovf       = stg[NBLK-1].g_last.ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench: directed vectors on the 16/4 instance, random streams on 8/8, 32/4, 32/8.
module tb_csel_adder_pipe;
  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    int          s0;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: returns {ovf, cout, sum[31:0]}
  function automatic logic [33:0] model(input logic [31:0] xa, input logic [31:0] xb,
                                        input logic c, input logic s, input int w);
    logic [31:0] m, x, y, r;
    logic [32:0] full;
    logic co, ov;
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    x = xa & m;
    y = xb & m;
    if (s) begin
      r  = (x - y) & m;
      co = (x >= y);
      ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
    end else begin
      full = {1'b0, x} + {1'b0, y} + {32'd0, c};
      r  = full[31:0] & m;
      co = full[w];
      ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
    end
    return {ov, co, r};
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int W  = (i == 0) ? 16 : (i == 1) ? 8 : 32;
    localparam int B  = (i == 1 || i == 3) ? 8 : 4;
    localparam int NB = W / B;

    logic         rst_n, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, sum;
    exp_t         sb[$];
    int           nstall = 0;
    bit           prev_hold = 0;

    csel_adder_pipe #(.WIDTH(W), .BLOCK(B)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
    );

    always @(posedge clk) if (out_valid && !out_ready) nstall++;

    task automatic lchk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      chk($sformatf("i%0d(W%0d,B%0d) %s", i, W, B, nm), act, exp);
    endtask

    // Monitor: compare the presented beat with the scoreboard head every cycle
    always @(negedge clk) begin
      if (!rst_n) begin
        prev_hold = 0;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            lchk("stale/extra beat out_valid", 64'(out_valid), 0);
          end else begin
            if (!prev_hold)
              lchk("latency", 64'(cyc), 64'(sb[0].acc + NB + (nstall - sb[0].s0)));
            lchk("sum", 64'(sum), 64'(sb[0].sum));
            lchk("cout", 64'(cout), 64'(sb[0].cout));
            lchk("ovf", 64'(ovf), 64'(sb[0].ovf));
            if (!out_ready) lchk("in_ready during stall", 64'(in_ready), 0);
            else void'(sb.pop_front());
          end
        end
        prev_hold = out_valid && !out_ready;
      end
    end

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                        input logic xs, input logic [W-1:0] es, input logic ec, input logic eo);
      exp_t e;
      int g;
      a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) lchk("accept timeout in_ready", 64'(in_ready), 1);
      e.sum = 32'(es); e.cout = ec; e.ovf = eo; e.acc = cyc; e.s0 = nstall;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                          input logic xs);
      logic [33:0] r;
      r = model(32'(xa), 32'(xb), xc, xs, W);
      send(xa, xb, xc, xs, r[W-1:0], r[32], r[33]);
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic wait_drain();
      int g = 0;
      while (sb.size() != 0 && g < 300) begin
        @(posedge clk);
        g++;
      end
      lchk("drain queue size", 64'(sb.size()), 0);
      @(posedge clk);
      #1;
    endtask

    if (i == 0) begin : g_stim
      initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        idle(2);
        lchk("reset out_valid", 64'(out_valid), 0);
        lchk("reset sum", 64'(sum), 0);
        lchk("reset cout", 64'(cout), 0);
        lchk("reset ovf", 64'(ovf), 0);
        lchk("reset in_ready", 64'(in_ready), 1);
        rst_n = 1'b1;
        idle(1);

        send(16'd2, 16'd2, 1'b1, 1'b0, 16'd5, 1'b0, 1'b0);
        wait_drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'd100, 16'd3, 1'b1, 1'b1, 16'd97, 1'b1, 1'b0);
        send(16'd3, 16'd12, 1'b0, 1'b1, 16'hFFF7, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        wait_drain();

        // six beats with bubbles, output stalled 3 cycles once it becomes valid
        fork
          begin
            send(16'd1, 16'd1, 1'b0, 1'b0, 16'd2, 1'b0, 1'b0);
            send(16'd10, 16'd5, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0);
            idle(1);
            send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
            send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
            idle(2);
            send(16'd5, 16'd7, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
            send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
          end
          begin
            int g = 0;
            while (!out_valid && g < 100) begin
              @(posedge clk);
              #1;
              g++;
            end
            out_ready = 1'b0;
            idle(3);
            out_ready = 1'b1;
          end
        join
        wait_drain();

        // asynchronous reset with the pipe full
        send(16'd1, 16'd2, 1'b0, 1'b0, 16'd3, 1'b0, 1'b0);
        send(16'd5, 16'd5, 1'b0, 1'b0, 16'd10, 1'b0, 1'b0);
        send(16'd9, 16'd4, 1'b0, 1'b1, 16'd5, 1'b1, 1'b0);
        send(16'd7, 16'd7, 1'b1, 1'b0, 16'd15, 1'b0, 1'b0);
        lchk("pre-reset out_valid", 64'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        lchk("async reset out_valid", 64'(out_valid), 0);
        idle(2);
        rst_n = 1'b1;
        idle(8);
        send(16'd12, 16'd3, 1'b1, 1'b0, 16'd16, 1'b0, 1'b0);
        wait_drain();
        done_cnt++;
      end
    end else begin : g_stim
      bit rnd_on = 0;

      initial begin
        out_ready = 1'b1;
        forever begin
          @(posedge clk);
          #1;
          out_ready = rnd_on ? ($urandom_range(9) < 7) : 1'b1;
        end
      end

      initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        rnd_on = 1;
        send_m('1, '1, 1'b1, 1'b0);
        send_m({1'b1, {(W-1){1'b0}}}, W'(1), 1'b0, 1'b1);
        send_m({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0);
        send_m('0, '0, 1'b0, 1'b1);
        for (int j = 0; j < 150; j++) begin
          if ($urandom_range(3) == 0) idle(1);
          send_m(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        rnd_on = 0;
        wait_drain();
        done_cnt++;
      end
    end
  end

  initial begin
    int g = 0;
    while (done_cnt < 4 && g < 50000) begin
      @(posedge clk);
      g++;
    end
    if (done_cnt < 4) chk("completion done_cnt", 64'(done_cnt), 4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
